// File: rtl/frame_mem_master.sv
// frame_mem_master
//   Command initiator for the 12-bit pixel frame memory controller.
//   A start pulse in IDLE launches one frame transfer. WRITE mode takes pixels from the
//   s_* stream and writes them to memory. READ mode fetches the pixels in raster order
//   and sends them out on the m_* stream. The block issues one command per pixel and
//   uses cmd_done to track whether the controller has accepted and completed it.
//   Optional build macro: FRAME_MEM_TIMEOUT_EN adds a per-command watchdog that drives err_o.
module frame_mem_master #(
  parameter int unsigned FRAME_PIX = 307200,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_o,
  output logic              cmd_valid_o,
  output logic [7:0]        cmd_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] r_addr_o,
  output logic [DATA_W-1:0] data_in_o,
  input  logic              cmd_done_i,
  input  logic [DATA_W-1:0] data_out_i
);

  localparam logic [7:0] CMD_NONE  = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int unsigned          GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0]    LAST_PIX = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic {
    MODE_WRITE = 1'b0,
    MODE_READ  = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_OUT,
    ST_GAP,
    ST_FIN
  } state_e;

  state_e              state_q;
  mode_e               mode_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                cmd_valid_q;
  logic [7:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_in_q;
  logic [DATA_W-1:0]   m_data_q;
  logic                m_valid_q;
  logic                s_ready_q;
  logic [ADDR_W-1:0]   count_q;
  logic [GAP_W-1:0]    gap_q;
  logic                wd_trip;
  logic                start_acc;

  // A start pulse counts only in IDLE. While a frame is running it has no effect.
  assign start_acc = start_i && (state_q == ST_IDLE);

`ifdef FRAME_MEM_TIMEOUT_EN
  localparam int unsigned      WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign wd_trip = ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)) && (wd_q == WD_LAST);
  assign err_o   = err_q;

  // Watchdog: counts the cycles spent waiting on the controller for the current command.
  // The error flag is sticky and is cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)) begin
        wd_q <= wd_q + 1'b1;
      end else begin
        wd_q <= '0;
      end
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (wd_trip) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_trip = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Frame sequencer. It walks each pixel through load, issue, handshake, optional output and gap.
  // NOTE: every register here uses non-blocking assignments. All of them are read in the
  // same block, so they must update together at the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the async reset clears every control and datapath register. This block holds
    // no memory array, so nothing is left out of the reset.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_WRITE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= CMD_NONE;
      addr_q       <= '0;
      data_in_q    <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      s_ready_q    <= 1'b0;
      count_q      <= '0;
      gap_q        <= '0;
    end else begin
      // NOTE: this default makes frame_done a one-cycle pulse. Only the branch that
      // finishes a frame overrides it.
      frame_done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            mode_q    <= mode_e'(mode_i);
            busy_q    <= 1'b1;
            s_ready_q <= (mode_e'(mode_i) == MODE_WRITE);
            state_q   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (mode_q == MODE_READ) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_READ;
            addr_q      <= count_q;
            state_q     <= ST_ISSUE;
          end else if (s_valid_i && s_ready_q) begin
            data_in_q   <= s_data_i;
            s_ready_q   <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_WRITE;
            addr_q      <= count_q;
            state_q     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          state_q <= ST_WAIT_ACK;
        end

        // The controller shows it has accepted the command by pulling cmd_done low.
        ST_WAIT_ACK: begin
          if (wd_trip) begin
            cmd_valid_q  <= 1'b0;
            cmd_q        <= CMD_NONE;
            frame_done_q <= 1'b1;
            state_q      <= ST_FIN;
          end else if (!cmd_done_i) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NONE;
            state_q     <= ST_WAIT_DONE;
          end
        end

        // cmd_done rising again means the command is complete. For a read, data_out is valid now.
        ST_WAIT_DONE: begin
          if (wd_trip) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_FIN;
          end else if (cmd_done_i) begin
            gap_q <= '0;
            if (mode_q == MODE_READ) begin
              m_data_q  <= data_out_i;
              m_valid_q <= 1'b1;
              state_q   <= ST_OUT;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end

        // Backpressure on the output stream can hold this state indefinitely.
        ST_OUT: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= ST_GAP;
          end
        end

        // The idle gap gives the clk/4 responder time to return to its wait state
        // before the next command.
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (count_q == LAST_PIX) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_FIN;
            end else begin
              count_q   <= count_q + 1'b1;
              s_ready_q <= (mode_q == MODE_WRITE);
              state_q   <= ST_LOAD;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        ST_FIN: begin
          busy_q  <= 1'b0;
          count_q <= '0;
          addr_q  <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_o        = cmd_q;
  assign w_addr_o     = addr_q;
  assign r_addr_o     = addr_q;
  assign data_in_o    = data_in_q;
  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign s_ready_o    = s_ready_q;

  // A read result on the output stream and a command to the controller are never live together.
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(m_valid_q && cmd_valid_q));

  // The address never goes past the last pixel of the frame.
  a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    addr_q <= LAST_PIX);

endmodule

// File: tb/tb_frame_mem_master.sv
// Testbench for frame_mem_master, using a 16-pixel frame.
// A controller model handles the cmd_valid/cmd_done handshake and holds the memory.
// A frame-level model predicts the command sequence and the output pixel stream.
module tb_frame_mem_master;

  localparam int FRAME_PIX = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 12;
  localparam int GAP_CYC   = 8;
  localparam int TIMEOUT   = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start, mode, s_valid, s_ready, m_valid, m_ready;
  logic [DATA_W-1:0] s_data, m_data, data_in, data_out;
  logic              busy, frame_done, err, cmd_valid, cmd_done;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] w_addr, r_addr;

  frame_mem_master #(
    .FRAME_PIX(FRAME_PIX), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start), .mode_i(mode),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .busy_o(busy), .frame_done_o(frame_done), .err_o(err),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .w_addr_o(w_addr), .r_addr_o(r_addr),
    .data_in_o(data_in), .cmd_done_i(cmd_done), .data_out_i(data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic [DATA_W-1:0] mem     [FRAME_PIX];  // controller memory
  logic [DATA_W-1:0] exp_pix [FRAME_PIX];  // what the frame should contain
  int   exp_idx  = 0;   // next expected command index in this frame
  logic exp_mode = 1'b0;
  int   out_idx  = 0;   // next expected output pixel
  int   fd_cnt   = 0;
  int   n_cmds   = 0;
  int   low_cnt  = GAP_CYC + 1;
  bit   stuck    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Controller model. It accepts 2 cycles after cmd_valid appears and completes 3 cycles later.
  initial begin
    int phase;
    int cnt;
    logic [7:0]        lcmd;
    logic [ADDR_W-1:0] laddr;
    logic [DATA_W-1:0] ldata;
    phase = 0; cnt = 0; lcmd = '0; laddr = '0; ldata = '0;
    cmd_done = 1'b1;
    data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || stuck) begin
        phase = 0; cmd_done = 1'b1; low_cnt = GAP_CYC + 1;
      end else begin
        case (phase)
          0: begin
            if (cmd_valid) begin
              check("cmd_gap", 32'(low_cnt >= GAP_CYC + 1), 32'd1);
              check("cmd_code", 32'(cmd), exp_mode ? 32'h01 : 32'h02);
              check("w_addr", 32'(w_addr), 32'(exp_idx));
              check("r_addr", 32'(r_addr), 32'(exp_idx));
              if (!exp_mode && exp_idx < FRAME_PIX) check("wr_data", 32'(data_in), 32'(exp_pix[exp_idx]));
              lcmd = cmd; laddr = w_addr; ldata = data_in;
              exp_idx++; n_cmds++;
              phase = 1; cnt = 0;
            end else begin
              low_cnt++;
            end
          end
          1: begin
            check("cmd_hold", 32'({cmd_valid, cmd, w_addr, data_in}), 32'({1'b1, lcmd, laddr, ldata}));
            cnt++;
            if (cnt == 2) begin cmd_done = 1'b0; phase = 2; cnt = 0; end
          end
          default: begin
            cnt++;
            if (cnt == 3) begin
              if (lcmd == 8'h02) mem[laddr] = ldata;
              else data_out = mem[laddr];
              cmd_done = 1'b1; phase = 0; low_cnt = 0;
            end
          end
        endcase
      end
    end
  end

  // Output-side compare. It runs on every cycle and checks the stream, exclusivity and frame end.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_valid) begin
          check("m_data", 32'(m_data), (out_idx < FRAME_PIX) ? 32'(exp_pix[out_idx]) : 32'hDEAD);
          check("m_vs_cmd", 32'(cmd_valid), 32'd0);
          if (m_ready) out_idx++;
        end
        if (busy && exp_mode) check("s_ready_rd", 32'(s_ready), 32'd0);
        if (frame_done) begin
          fd_cnt++;
          check("fd_busy", 32'(busy), 32'd1);
          if (!stuck) begin
            check("fd_cmds", 32'(exp_idx), 32'(FRAME_PIX));
            if (exp_mode) check("fd_out", 32'(out_idx), 32'(FRAME_PIX));
          end
        end
      end
    end
  end

  task automatic start_frame(input logic m);
    exp_mode = m; exp_idx = 0; out_idx = 0;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_fd(input int target, input string nm);
    int t;
    t = 0;
    while (fd_cnt < target && t < 3000) begin @(posedge clk); t++; end
    check(nm, 32'(fd_cnt >= target), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Feeds pixel k = k. While pixel 7 is in flight it pulses a READ start that must be ignored.
  task automatic feed_frame();
    for (int k = 0; k < FRAME_PIX; k++) begin
      int t;
      t = 0;
      s_valid = 1'b1; s_data = DATA_W'(k);
      do begin @(negedge clk); t++; end while (!s_ready && t < 400);
      if (!s_ready) begin check("s_ready_wait", 32'd0, 32'd1); break; end
      @(posedge clk); #1;
      if (k == 7) begin
        start = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'b0;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd"}, 32'(cmd), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_addrs"}, 32'({w_addr, r_addr}), 32'd0);
    check({tag, "_data"}, 32'({data_in, m_data}), 32'd0);
  endtask

  initial begin
    int t;
    start = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int k = 0; k < FRAME_PIX; k++) begin
      exp_pix[k] = DATA_W'(k);
      mem[k]     = '0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WRITE frame. A start pulse mid-frame is ignored. m_ready is high but unused in this mode.
    start_frame(1'b0);
    feed_frame();
    wait_fd(1, "write_fd_wait");
    check("write_mem5", 32'(mem[5]), 32'h005);
    check("write_mem15", 32'(mem[15]), 32'h00F);
    check("write_fd_once", 32'(fd_cnt), 32'd1);
    check("write_ncmds", 32'(n_cmds), 32'd16);
    check("write_idle_busy", 32'(busy), 32'd0);
    check("write_idle_addr", 32'(w_addr), 32'd0);

    // READ frame with a 20-cycle stall on pixel 5
    start_frame(1'b1);
    t = 0;
    while (out_idx < 5 && t < 2000) begin @(posedge clk); t++; end
    #1 m_ready = 1'b0;
    t = 0;
    while (!m_valid && t < 200) begin @(negedge clk); t++; end
    check("stall_reached", 32'(m_valid), 32'd1);
    repeat (20) @(negedge clk);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_data", 32'(m_data), 32'h005);
    check("stall_nocmd", 32'(n_cmds), 32'd22);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_fd(2, "read_fd_wait");
    check("read_out_count", 32'(out_idx), 32'd16);
    check("read_fd_once", 32'(fd_cnt), 32'd2);

    // Reset during WAIT_DONE of pixel 3, then restart from address 0
    start_frame(1'b1);
    t = 0;
    while (!(exp_idx == 4 && cmd_done == 1'b0) && t < 2000) begin @(posedge clk); t++; end
    check("rst_point", 32'(exp_idx), 32'd4);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start_frame(1'b1);
    wait_fd(3, "restart_fd_wait");
    check("restart_out_count", 32'(out_idx), 32'd16);
    check("restart_fd_total", 32'(fd_cnt), 32'd3);

`ifdef FRAME_MEM_TIMEOUT_EN
    // Controller stuck with cmd_done=1: the watchdog aborts the frame
    stuck = 1'b1;
    start_frame(1'b1);
    wait_fd(4, "timeout_fd_wait");
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    stuck = 1'b0;
    @(posedge clk); #1;
    start_frame(1'b1);
    check("timeout_err_clr", 32'(err), 32'd0);
    wait_fd(5, "post_timeout_fd_wait");
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
